spi_frame_tx: RTL and testbench

//  Parametrised SPI slave that streams trace words to the host as fixed frames
//  (one header byte, then FRAME_WORDS payload words), with a write FIFO in front.
//  All logic runs on clk. SCLK/MOSI/CS_N are synchronised and edge-detected; none of them clocks any flop.

---
 rtl/spi_frame_tx.sv | 218 +++++++++++++++++++++
 tb/tb_spi_frame_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_tx.sv
// rtl/spi_frame_tx.sv - SPI slave streaming fixed header+payload frames from a write FIFO
module spi_frame_tx #(
  parameter int WORD_W      = 16,
  parameter int FRAME_WORDS = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int LED_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spi_sclk,
  input  logic                          spi_mosi,
  input  logic                          spi_cs_n,
  output logic                          spi_miso,
  input  logic [WORD_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          sync,
  output logic [1:0]                    width,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rx_frame_reset,
  output logic                          is_transmitting
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WORD_W + 1);
  localparam int IW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic {ST_HDR, ST_WORD} tx_state_t;

  // Synchronisers: [1] is the synchronised level, [2] the previous level
  logic [2:0] sclk_q, mosi_q, csn_q;
  logic       sclk_rise, sclk_fall;
  logic       cs_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q    <= 3'b000;
      mosi_q    <= 3'b000;
      csn_q     <= 3'b111;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[1:0], spi_sclk};
      mosi_q    <= {mosi_q[1:0], spi_mosi};
      csn_q     <= {csn_q[1:0], spi_cs_n};
      sclk_rise <= sclk_q[1] & ~sclk_q[2];
      sclk_fall <= ~sclk_q[1] & sclk_q[2];
    end
  end

  assign cs_active = ~csn_q[2];

  // Write FIFO
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              push, pop;
  logic [WORD_W-1:0] fifo_rd;

  assign in_ready = (fifo_level != LW'(FIFO_DEPTH)) | pop;
  assign push     = in_valid & in_ready;
  assign fifo_rd  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Command receiver
  logic [7:0] rx_sr, rx_new;
  logic [2:0] rx_bitcnt;
  logic       restart;

  assign rx_new = {rx_sr[6:0], mosi_q[2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr          <= '0;
      rx_bitcnt      <= '0;
      rx_frame_reset <= 1'b0;
      width          <= 2'd3;
      restart        <= 1'b0;
    end else begin
      rx_frame_reset <= 1'b0;
      if (!cs_active) begin
        rx_bitcnt <= '0;
        restart   <= 1'b0;
      end else begin
        if (sclk_rise && restart) restart <= 1'b0;
        if (sclk_fall) begin
          rx_sr <= rx_new;
          if (rx_new == 8'hA5) begin
            rx_bitcnt      <= '0;
            rx_frame_reset <= 1'b1;
          end else begin
            rx_bitcnt <= rx_bitcnt + 3'd1;
            if (rx_bitcnt == 3'd7 && (rx_new & 8'hF1) == 8'hA0) begin
              width   <= rx_new[3:2];
              restart <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Transmitter: tx_sr holds the current item with the next bit at the MSB
  tx_state_t         state, state_n;
  logic [WORD_W-1:0] tx_sr, sr_n, hdr_vec;
  logic [CW-1:0]     bits_left, bits_n;
  logic [IW-1:0]     word_idx, widx_n;
  logic              frame_real, real_n, miso_n;
  logic              hdr_real;
  logic [7:0]        hdr_byte;

  function automatic logic [WORD_W-1:0] swap_bytes(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    for (int k = 0; k < WORD_W / 8; k++) r[WORD_W-1-8*k -: 8] = w[8*k +: 8];
    return r;
  endfunction

  assign hdr_real = fifo_level >= LW'(FRAME_WORDS);
  assign hdr_byte = {~hdr_real, 4'b0000, width, sync};
  assign hdr_vec  = WORD_W'(hdr_byte) << (WORD_W - 8);

  always_comb begin
    state_n = state;
    sr_n    = tx_sr;
    bits_n  = bits_left;
    widx_n  = word_idx;
    real_n  = frame_real;
    miso_n  = spi_miso;
    pop     = 1'b0;
    if (!cs_active) begin
      state_n = ST_HDR;
      sr_n    = hdr_vec;
      bits_n  = CW'(8);
      widx_n  = '0;
      real_n  = hdr_real;
      miso_n  = 1'b0;
    end else if (sclk_rise) begin
      if (restart) begin
        // The fresh header goes out on this very edge
        state_n = ST_HDR;
        miso_n  = hdr_byte[7];
        sr_n    = hdr_vec << 1;
        bits_n  = CW'(7);
        widx_n  = '0;
        real_n  = hdr_real;
      end else begin
        miso_n = tx_sr[WORD_W-1];
        if (bits_left == CW'(1)) begin
          if (state == ST_HDR || word_idx != IW'(FRAME_WORDS - 1)) begin
            state_n = ST_WORD;
            widx_n  = (state == ST_HDR) ? '0 : word_idx + IW'(1);
            sr_n    = frame_real ? swap_bytes(fifo_rd) : '0;
            pop     = frame_real;
            bits_n  = CW'(WORD_W);
          end else begin
            state_n = ST_HDR;
            sr_n    = hdr_vec;
            bits_n  = CW'(8);
            widx_n  = '0;
            real_n  = hdr_real;
          end
        end else begin
          sr_n   = tx_sr << 1;
          bits_n = bits_left - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HDR;
      tx_sr      <= WORD_W'(8'h86) << (WORD_W - 8);
      bits_left  <= CW'(8);
      word_idx   <= '0;
      frame_real <= 1'b0;
      spi_miso   <= 1'b0;
    end else begin
      state      <= state_n;
      tx_sr      <= sr_n;
      bits_left  <= bits_n;
      word_idx   <= widx_n;
      frame_real <= real_n;
      spi_miso   <= miso_n;
    end
  end

  // Activity LED stretch
  logic [LED_W-1:0] led_cnt;

  always_ff @(posedge clk) begin
    if (rst)                          led_cnt <= '0;
    else if (frame_real && cs_active) led_cnt <= '1;
    else if (led_cnt != '0)           led_cnt <= led_cnt - LED_W'(1);
  end

  assign is_transmitting = (led_cnt != '0);

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb/tb_spi_frame_tx.sv - directed self-checking bench for spi_frame_tx
module tb_spi_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_miso;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sync = 1'b0;
  logic [1:0]  width;
  logic [4:0]  fifo_level;
  logic        rx_frame_reset;
  logic        is_transmitting;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  spi_frame_tx #(.WORD_W(16), .FRAME_WORDS(8), .FIFO_DEPTH(16), .LED_W(16)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sync(sync), .width(width), .fifo_level(fifo_level), .rx_frame_reset(rx_frame_reset),
    .is_transmitting(is_transmitting)
  );

  always @(negedge clk) if (rx_frame_reset) pulse_cnt++;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host: drive MOSI and raise SCLK, sample MISO just before the falling edge
  task automatic spi_shift(input int n, input logic [31:0] mo, output logic [135:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      spi_mosi = (n - 1 - i < 32) ? mo[n-1-i] : 1'b0;
      spi_sclk = 1'b1;
      clks(8);
      mi = {mi[134:0], spi_miso};
      spi_sclk = 1'b0;
      clks(8);
    end
  endtask

  task automatic cs_on();
    @(negedge clk); spi_cs_n = 1'b0; clks(8);
  endtask

  task automatic cs_off();
    @(negedge clk); spi_cs_n = 1'b1; clks(8);
  endtask

  task automatic push_word(input logic [15:0] d);
    @(negedge clk); in_valid = 1'b1; in_data = d;
    @(negedge clk); in_valid = 1'b0;
  endtask

  function automatic logic [127:0] exp_payload(input logic [15:0] base);
    logic [127:0] p = '0;
    logic [15:0]  w;
    for (int k = 0; k < 8; k++) begin
      w = base + 16'(k);
      p = {p[111:0], w[7:0], w[15:8]};
    end
    return p;
  endfunction

  logic [135:0] mi;
  logic         acc;
  int           pc0;

  initial begin
    clks(4);
    rst = 1'b0;
    clks(2);
    check_eq("rst_miso", spi_miso, 1'b0);
    check_eq("rst_width", width, 2'd3);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_level", fifo_level, 5'd0);
    check_eq("rst_led", is_transmitting, 1'b0);
    check_eq("rst_rx_reset", rx_frame_reset, 1'b0);

    // Idle frames back to back
    cs_on();
    spi_shift(136, 32'h0, mi);
    check_eq("idle_hdr0", mi[135:128], 8'h86);
    check_eq("idle_pay0", mi[127:0], 128'h0);
    spi_shift(136, 32'h0, mi);
    check_eq("idle_hdr1", mi[135:128], 8'h86);
    check_eq("idle_pay1", mi[127:0], 128'h0);
    check_eq("idle_led", is_transmitting, 1'b0);

    // Real frame
    cs_off();
    for (int i = 0; i < 8; i++) push_word(16'h1234 + 16'(i));
    check_eq("real_level_in", fifo_level, 5'd8);
    cs_on();
    spi_shift(136, 32'h0, mi);
    check_eq("real_hdr", mi[135:128], 8'h06);
    check_eq("real_pay", mi[127:0], exp_payload(16'h1234));
    check_eq("real_level_out", fifo_level, 5'd0);
    check_eq("real_led", is_transmitting, 1'b1);

    // Width command mid-frame forces a fresh header
    cs_off();
    cs_on();
    spi_shift(24, 32'h0000A8, mi);
    check_eq("cmd_width2", width, 2'd2);
    spi_shift(8, 32'h0, mi);
    check_eq("restart_hdr", mi[7:0], 8'h84);

    sync = 1'b1;
    cs_off();
    cs_on();
    spi_shift(8, 32'h0, mi);
    check_eq("sync_hdr", mi[7:0], 8'h85);
    sync = 1'b0;

    // Resync byte after junk bits, then a width command
    cs_off();
    cs_on();
    pc0 = pulse_cnt;
    spi_shift(19, 32'h0A5A4, mi);
    check_eq("resync_pulse", 32'(pulse_cnt - pc0), 32'd1);
    check_eq("cmd_width1", width, 2'd1);
    spi_shift(8, 32'h0, mi);
    check_eq("resync_hdr", mi[7:0], 8'h82);

    // Full FIFO, push accepted during a pop, cs_n high mid-word
    cs_off();
    for (int i = 0; i < 16; i++) push_word(16'h5000 + 16'(i));
    check_eq("full_level", fifo_level, 5'd16);
    check_eq("full_ready", in_ready, 1'b0);
    cs_on();
    @(negedge clk); in_valid = 1'b1; in_data = 16'hBEEF;
    acc = 1'b0;
    fork
      spi_shift(8, 32'h0, mi);
      begin
        for (int t = 0; t < 400 && !acc; t++) begin
          @(negedge clk);
          if (in_ready) acc = 1'b1;
        end
        @(negedge clk); in_valid = 1'b0;
        check_eq("pushpop_level", fifo_level, 5'd16);
      end
    join
    check_eq("pushpop_accept", acc, 1'b1);
    check_eq("full_hdr", mi[7:0], 8'h02);
    spi_shift(5, 32'h0, mi);
    cs_off();
    check_eq("csoff_miso", spi_miso, 1'b0);
    check_eq("csoff_level", fifo_level, 5'd16);
    cs_on();
    spi_shift(136, 32'h0, mi);
    check_eq("after_cs_hdr", mi[135:128], 8'h02);
    check_eq("after_cs_pay", mi[127:0], exp_payload(16'h5001));
    check_eq("after_cs_level", fifo_level, 5'd8);
    check_eq("after_cs_led", is_transmitting, 1'b1);

    // Reset mid-frame
    spi_shift(20, 32'h0, mi);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_eq("mid_rst_width", width, 2'd3);
    check_eq("mid_rst_level", fifo_level, 5'd0);
    check_eq("mid_rst_miso", spi_miso, 1'b0);
    check_eq("mid_rst_ready", in_ready, 1'b1);
    check_eq("mid_rst_led", is_transmitting, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
